// File: rtl/ks_wide_add_seq_pkg.sv
// Shared definitions for the sliced wide adder: operation codes, FSM states
// and the Kogge-Stone prefix cells used by the slice adder.
package ks_seq_pkg;

   localparam logic [1:0] MODE_ADD  = 2'b00;
   localparam logic [1:0] MODE_ADD1 = 2'b01;
   localparam logic [1:0] MODE_INC  = 2'b10;
   localparam logic [1:0] MODE_SUB  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Black node: merges a higher (g,p) group with the adjacent lower group.
   function automatic logic [1:0] black_cell(input logic gHi, input logic pHi,
                                             input logic gLo, input logic pLo);
      return {gHi | (pHi & gLo), pHi & pLo};
   endfunction

   function automatic logic grey_cell(input logic gHi, input logic pHi, input logic gLo);
      return gHi | (pHi & gLo);
   endfunction

   function automatic logic sum_cell(input logic p, input logic c);
      return p ^ c;
   endfunction

endpackage

// File: rtl/ks_slice_adder.sv
// Combinational W-bit Kogge-Stone adder with carry-in, carry-out and the
// carry into the MSB (needed by the sequencer for signed overflow).
module ks_slice_adder
   import ks_seq_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] sum_o,
   output logic         cout_o,
   output logic         cmsb_o
);

   localparam int LEVELS = $clog2(W);

   logic [W-1:0] gen  [0:LEVELS];
   logic [W-1:0] prop [0:LEVELS];
   logic [W-1:0] halfSum;
   logic [W:0]   carry;

   // The carry-in is folded into bit 0's generate so every prefix G[i:0]
   // already includes it and the final level yields carries directly.
   always_comb begin
      for (int l = 0; l <= LEVELS; l++) begin
         gen[l]  = '0;
         prop[l] = '0;
      end
      halfSum = a_i ^ b_i;
      gen[0]  = a_i & b_i;
      prop[0] = halfSum;
      gen[0][0] = grey_cell(gen[0][0], prop[0][0], cin_i);

      for (int l = 1; l <= LEVELS; l++) begin
         gen[l]  = gen[l-1];
         prop[l] = prop[l-1];
         for (int i = (1 << (l - 1)); i < W; i++) begin
            if (i >= (2 << (l - 1))) begin
               {gen[l][i], prop[l][i]} = black_cell(gen[l-1][i], prop[l-1][i],
                                                    gen[l-1][i - (1 << (l - 1))],
                                                    prop[l-1][i - (1 << (l - 1))]);
            end else begin
               gen[l][i] = grey_cell(gen[l-1][i], prop[l-1][i],
                                     gen[l-1][i - (1 << (l - 1))]);
            end
         end
      end

      carry[0]   = cin_i;
      carry[W:1] = gen[LEVELS];
      sum_o = '0;
      for (int i = 0; i < W; i++) begin
         sum_o[i] = sum_cell(halfSum[i], carry[i]);
      end
   end

   assign cout_o = carry[W];
   assign cmsb_o = carry[W-1];

endmodule

// File: rtl/ks_wide_add_seq.sv
// Wide add/increment/subtract that streams W-bit slices, LSB first, through a
// single shared Kogge-Stone slice adder, one slice per clock.
module ks_wide_add_seq
   import ks_seq_pkg::*;
#(
   parameter int W      = 16,
   parameter int SLICES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [W*SLICES-1:0]   op_a,
   input  logic [W*SLICES-1:0]   op_b,
   input  logic [1:0]            mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [W*SLICES-1:0]   sum,
   output logic                  cout,
   output logic                  ovf
);

   localparam int N  = W * SLICES;
   localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam logic [IW-1:0] LastIdx = IW'(SLICES - 1);

   state_e        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          carry_q, carry_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic [N-1:0]  sum_q, sum_d;
   logic          cout_q, cout_d;
   logic          ovf_q, ovf_d;

   logic [W-1:0]  sliceSum;
   logic          sliceCout;
   logic          sliceCmsb;

   // The captured operands shift right each RUN cycle, so the active slice
   // always sits in the low W bits and no wide operand mux is needed.
   ks_slice_adder #(.W(W)) u_slice (
      .a_i    (a_q[W-1:0]),
      .b_i    (b_q[W-1:0]),
      .cin_i  (carry_q),
      .sum_o  (sliceSum),
      .cout_o (sliceCout),
      .cmsb_o (sliceCmsb)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = RUN;
               idx_d   = '0;
               a_d     = op_a;
               case (mode)
                  MODE_ADD:  begin b_d = op_b;  carry_d = 1'b0; end
                  MODE_ADD1: begin b_d = op_b;  carry_d = 1'b1; end
                  MODE_INC:  begin b_d = '0;    carry_d = 1'b1; end
                  MODE_SUB:  begin b_d = ~op_b; carry_d = 1'b1; end
               endcase
            end
         end
         RUN: begin
            a_d     = a_q >> W;
            b_d     = b_q >> W;
            carry_d = sliceCout;
            idx_d   = idx_q + 1'b1;
            for (int k = 0; k < SLICES; k++) begin
               if (idx_q == IW'(k)) begin
                  sum_d[k*W +: W] = sliceSum;
               end
            end
            if (idx_q == LastIdx) begin
               state_d = DONE;
               idx_d   = '0;
               cout_d  = sliceCout;
               ovf_d   = sliceCmsb ^ sliceCout;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_ks_wide_add_seq.sv
// Self-checking bench for ks_wide_add_seq: directed corner cases plus random
// operations compared against a plain-arithmetic model of the wide operation.
module tb_ks_wide_add_seq;
   import ks_seq_pkg::*;

   localparam int W      = 16;
   localparam int SLICES = 4;
   localparam int N      = W * SLICES;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] op_a = '0;
   logic [N-1:0] op_b = '0;
   logic [1:0]   mode = 2'b00;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [N-1:0] sum;
   logic         cout;
   logic         ovf;

   int nVectors = 0;
   int nMiscompares = 0;

   always #5 clk = ~clk;

   ks_wide_add_seq #(.W(W), .SLICES(SLICES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   // Returns {ovf, cout, sum}; overflow is judged by whether the exact signed
   // result fits in N bits, borrow by plain unsigned comparison.
   function automatic logic [N+1:0] refModel(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [1:0] m);
      logic [N:0]          wide;
      logic signed [N+1:0] sa, sb, st;
      sa = signed'({a[N-1], a[N-1], a});
      sb = signed'({b[N-1], b[N-1], b});
      case (m)
         MODE_ADD:  begin wide = {1'b0, a} + {1'b0, b}; st = sa + sb; end
         MODE_ADD1: begin wide = {1'b0, a} + {1'b0, b} + (N+1)'(1); st = sa + sb + (N+2)'(1); end
         MODE_INC:  begin wide = {1'b0, a} + (N+1)'(1); st = sa + (N+2)'(1); end
         default:   begin wide[N-1:0] = a - b; wide[N] = (a >= b); st = sa - sb; end
      endcase
      return {(st[N+1:N-1] != 3'b000) && (st[N+1:N-1] != 3'b111), wide[N], wide[N-1:0]};
   endfunction

   function automatic logic [N-1:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return '1;
         1:       return '0;
         2:       return {1'b1, {(N-1){1'b0}}};
         3:       return {1'b0, {(N-1){1'b1}}};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   // Drives one request from a negedge and collects the result; lat counts
   // clock edges from the accept edge to out_valid being seen.
   task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] m,
                                input int holdCycles, output logic [N+1:0] got,
                                output int lat, output bit timedOut);
      int waitCnt;
      timedOut = 1'b0;
      lat = 0;
      got = '0;
      waitCnt = 0;
      while (!in_ready && waitCnt < 20) begin
         @(negedge clk);
         waitCnt++;
      end
      if (!in_ready) begin
         timedOut = 1'b1;
         return;
      end
      op_a = a;
      op_b = b;
      mode = m;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      if (!out_valid) begin
         timedOut = 1'b1;
         return;
      end
      got = {ovf, cout, sum};
      repeat (holdCycles) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      nVectors++;
      if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, {N{1'b0}}, 1'b0, 1'b0}) begin
         nMiscompares++;
         $display("[TB] FAIL reset_values: got rdy=%b vld=%b sum=%h c=%b v=%b, want 1 0 0 0 0",
                  in_ready, out_valid, sum, cout, ovf);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic [1:0] m, input logic [N+1:0] want);
      logic [N+1:0] got;
      int           lat;
      bit           timedOut;
      applyStimulus(a, b, m, 0, got, lat, timedOut);
      nVectors++;
      if (timedOut) begin
         nMiscompares++;
         $display("[TB] FAIL %s_timeout: got no result, want out_valid", name);
      end
      nVectors++;
      if (lat !== SLICES) begin
         nMiscompares++;
         $display("[TB] FAIL %s_latency: got %0d edges, want %0d", name, lat, SLICES);
      end
      nVectors++;
      if (got !== want) begin
         nMiscompares++;
         $display("[TB] FAIL %s_result: got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
                  name, got[N+1], got[N], got[N-1:0], want[N+1], want[N], want[N-1:0]);
      end
   endtask

   task automatic test_backpressure();
      logic [N+1:0] want;
      int           waitCnt;
      want = refModel(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, MODE_ADD);
      op_a = 64'h0123_4567_89AB_CDEF;
      op_b = 64'h1111_2222_3333_4444;
      mode = MODE_ADD;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      waitCnt = 0;
      while (!out_valid && waitCnt < 20) begin
         @(posedge clk);
         @(negedge clk);
         waitCnt++;
      end
      in_valid = 1'b1;
      op_a = 64'hDEAD_BEEF_0000_0001;
      op_b = 64'h0000_0000_0000_0003;
      mode = MODE_SUB;
      for (int i = 0; i < 3; i++) begin
         nVectors++;
         if ({out_valid, in_ready} !== 2'b10 || {ovf, cout, sum} !== want) begin
            nMiscompares++;
            $display("[TB] FAIL bp_hold%0d: got vld=%b rdy=%b res=%h, want vld=1 rdy=0 res=%h",
                     i, out_valid, in_ready, {ovf, cout, sum}, want);
         end
         @(posedge clk);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      nVectors++;
      if ({in_ready, out_valid} !== 2'b10) begin
         nMiscompares++;
         $display("[TB] FAIL bp_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
      end
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op();
      logic [N+1:0] got;
      int           lat;
      bit           timedOut;
      bit           sawValid;
      op_a = 64'h7777_8888_9999_AAAA;
      op_b = 64'h1234_5678_9ABC_DEF0;
      mode = MODE_ADD;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      nVectors++;
      if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, {N{1'b0}}, 1'b0, 1'b0}) begin
         nMiscompares++;
         $display("[TB] FAIL midrst_values: got rdy=%b vld=%b sum=%h c=%b v=%b, want 1 0 0 0 0",
                  in_ready, out_valid, sum, cout, ovf);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sawValid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         sawValid |= out_valid;
      end
      nVectors++;
      if (sawValid !== 1'b0) begin
         nMiscompares++;
         $display("[TB] FAIL midrst_no_valid: got out_valid=%b, want 0", sawValid);
      end
      applyStimulus(64'd1, 64'd1, MODE_ADD, 0, got, lat, timedOut);
      nVectors++;
      if (timedOut || got[N-1:0] !== 64'd2) begin
         nMiscompares++;
         $display("[TB] FAIL midrst_fresh: got sum=%h timeout=%b, want sum=2", got[N-1:0], timedOut);
      end
   endtask

   task automatic test_random(input int count);
      logic [N-1:0] a, b;
      logic [1:0]   m;
      logic [N+1:0] got, want;
      int           lat;
      bit           timedOut;
      for (int i = 0; i < count; i++) begin
         a = pickOperand();
         b = pickOperand();
         m = 2'($urandom_range(0, 3));
         want = refModel(a, b, m);
         applyStimulus(a, b, m, $urandom_range(0, 2), got, lat, timedOut);
         nVectors++;
         if (timedOut || lat !== SLICES || got !== want) begin
            nMiscompares++;
            $display("[TB] FAIL rand%0d m=%b a=%h b=%h: got %h lat=%0d, want %h lat=%0d",
                     i, m, a, b, got, lat, want, SLICES);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [N+1:0] expQ[$];
      logic [N+1:0] want;
      int           cyc, lastAcc, accepts, guard;
      bit           accept;
      cyc = 0;
      lastAcc = -1;
      accepts = 0;
      op_a = {$urandom, $urandom};
      op_b = {$urandom, $urandom};
      mode = 2'($urandom_range(0, 3));
      in_valid = 1'b1;
      out_ready = 1'b1;
      while ((accepts < 3 || expQ.size() > 0) && cyc < 60) begin
         if (out_valid) begin
            nVectors++;
            want = (expQ.size() > 0) ? expQ.pop_front() : '0;
            if ({ovf, cout, sum} !== want) begin
               nMiscompares++;
               $display("[TB] FAIL b2b_result: got %h, want %h", {ovf, cout, sum}, want);
            end
         end
         accept = in_ready && in_valid;
         if (accept) begin
            if (lastAcc >= 0) begin
               nVectors++;
               if (cyc - lastAcc !== SLICES + 2) begin
                  nMiscompares++;
                  $display("[TB] FAIL b2b_spacing: got %0d cycles, want %0d", cyc - lastAcc, SLICES + 2);
               end
            end
            lastAcc = cyc;
            accepts++;
            expQ.push_back(refModel(op_a, op_b, mode));
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (accept) begin
            op_a = {$urandom, $urandom};
            op_b = {$urandom, $urandom};
            mode = 2'($urandom_range(0, 3));
            if (accepts >= 3) in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      guard = expQ.size();
      nVectors++;
      if (guard != 0 || accepts != 3) begin
         nMiscompares++;
         $display("[TB] FAIL b2b_drain: got %0d accepts %0d pending, want 3 accepts 0 pending",
                  accepts, guard);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_directed("carry_chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, MODE_ADD,
                    {1'b0, 1'b1, 64'h0000_0000_0000_0000});
      test_directed("inc_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1234, MODE_INC,
                    {1'b1, 1'b0, 64'h8000_0000_0000_0000});
      test_directed("inc_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h5555, MODE_INC,
                    {1'b0, 1'b1, 64'h0000_0000_0000_0000});
      test_directed("sub_borrow", 64'd5, 64'd7, MODE_SUB,
                    {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
      test_directed("add_cin", 64'h0000_FFFF_0000_FFFF, 64'd0, MODE_ADD1,
                    {1'b0, 1'b0, 64'h0000_FFFF_0001_0000});
      test_backpressure();
      test_reset_mid_op();
      test_random(40);
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule

// File: doc/ks_wide_add_seq.md
# ks_wide_add_seq

Multi-cycle sequencer that performs a wide addition, increment or subtraction by passing W-bit slices of the operands, least significant slice first, through a single shared Kogge-Stone slice adder, one slice per cycle. It registers the inter-slice carry, assembles the full-width result and reports carry-out and signed overflow. It sits between a valid/ready operand source and a valid/ready result sink. It lets the design reuse one narrow parallel-prefix adder instead of instantiating a full-width one.

## Interface
- W, 16, slice width in bits; the width of the shared Kogge-Stone adder.
- SLICES, 4, number of slices; the operand width is N = W*SLICES.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  the block can accept operands.
- op_a  in  N  operand A.
- op_b  in  N  operand B.
- mode  in  2  operation: 00 A+B; 01 A+B+1; 10 A+1 (op_b ignored); 11 A−B.
- out_valid  out  1  result available.
- out_ready  in  1  the sink accepts the result.
- sum  out  N  result.
- cout  out  1  carry out of the MSB. For A−B, 1 means no borrow.
- ovf  out  1  two's-complement overflow of the N-bit result.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - RUN: slice counter idx runs 0..SLICES−1.
  - DONE: out_valid=1.
- IDLE→RUN on in_valid&in_ready. On that edge the block captures:
  - A.
  - the effective B: op_b for modes 00 and 01; 0 for mode 10; ~op_b for mode 11.
  - the initial carry: 0 for mode 00; 1 for modes 01, 10 and 11.
  - idx is cleared to 0.
- Each RUN cycle:
  - The slice adder computes A[idx] + Beff[idx] + carry.
  - The W-bit result is written to sum[idx*W +: W].
  - carry is updated from the slice carry-out, and idx increments.
- On the edge where idx=SLICES−1, the FSM goes RUN→DONE. On that same edge:
  - cout takes the final carry-out.
  - ovf takes carry-into-MSB XOR carry-out-of-MSB, both taken from the top slice.
- DONE→IDLE on out_valid&out_ready.
- sum, cout and ovf hold stable throughout DONE.
- in_ready=0 in RUN and DONE. in_valid is ignored there, and operands presented then are not captured.
- There is no new-operand acceptance in the same cycle as the result handshake. in_ready rises one cycle after that handshake.
- Width rules:
  - All slice arithmetic is unsigned W+1 bit.
  - Results wrap modulo 2^N.
  - Mode 10 with A=all-ones gives sum=0, cout=1, ovf=0.
- Reset is asynchronous and may be asserted in any state:
  - state goes to IDLE; idx, carry and all result registers clear.
  - any operation in flight is discarded, and no out_valid is produced for it.
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.

## Timing
- Let E0 be the accept edge. Slice k is computed in the cycle after edge E0+k.
- out_valid rises after edge E0+SLICES: 4 edges later at the default parameters.
- The result stays valid until the sink handshake.
- Minimum spacing between accepts is SLICES+2 cycles (RUN×SLICES, DONE×1, IDLE×1), assuming out_ready is held at 1.
- The critical path is the carry register → slice adder (log2 W prefix levels) → sum and carry registers. There is no full-width combinational path.
- sum slices above idx are stale during RUN. Only the value in DONE is architecturally meaningful.

## Structure
- Package ks_seq_pkg holds:
  - the mode encoding constants MODE_ADD, MODE_ADD1, MODE_INC and MODE_SUB.
  - the state encoding IDLE, RUN and DONE.
- One sub-module, ks_slice_adder: a combinational W-bit Kogge-Stone adder with cin and cout that also exposes the carry into its MSB.
  - It is built from the team's existing prefix cells: generate/propagate, black/grey nodes and the sum-XOR cell.
  - It is instantiated once.
- The sequencer itself holds the FSM, idx, carry and the captured operand and result registers.

## Test plan
- Carry across every slice: mode 00, A=0xFFFF_FFFF_FFFF_FFFF, B=1.
  - Required: sum=0, cout=1, ovf=0.
  - out_valid rises exactly 4 edges after the accept edge.
- Signed overflow on increment: mode 10, A=0x7FFF_FFFF_FFFF_FFFF, B=0x1234 (ignored).
  - Required: sum=0x8000_0000_0000_0000, cout=0, ovf=1.
- Subtract with borrow: mode 11, A=5, B=7.
  - Required: sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
- Add with carry-in: mode 01, A=0x0000_FFFF_0000_FFFF, B=0.
  - Required: sum=0x0000_FFFF_0001_0000, cout=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands.
  - Required: sum, cout and ovf stay stable; in_ready=0; the new operands are not captured.
  - in_ready=1 one cycle after the out_ready handshake.
- Reset mid-operation: assert rst_n=0 while idx=2.
  - Required: all outputs read their reset values immediately, and no out_valid follows.
  - After release, a fresh mode 00 request 1+1 returns sum=2.
